// File: rtl/riscv_csr_unit.sv
// Machine-mode CSR unit: mie/mtvec/mscratch/mepc/mcause, a 64-bit cycle
// counter, trap/mret state tracking and a single external interrupt request.
`timescale 1ns/1ps
module riscv_csr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter int          IRQ_SYNC  = 1
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        csr_en_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  input  logic        irq_i,
  output logic        irq_req_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;

  localparam logic [1:0]  OP_READ  = 2'b00;
  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_CLEAR = 2'b10;
  localparam logic [1:0]  OP_SET   = 2'b11;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {ST_RUN, ST_TRAP} state_e;

  state_e      r_state;
  state_e      w_stateNext;
  logic        w_inRun;

  logic        r_mieMeie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [63:0] r_cycle;
  logic        r_irqPrev;
  logic        r_irqPending;

  logic        w_irqLevel;
  logic        w_irqRise;
  logic [31:0] w_csrVal;
  logic        w_known;
  logic        w_isCounter;
  logic        w_illegal;
  logic [31:0] w_wnew;
  logic        w_wrEn;
  logic [31:0] w_trapPcAligned;

  // Decode the addressed CSR and produce its pre-update value
  always_comb begin
    w_known  = 1'b1;
    w_csrVal = 32'h0;
    case (csr_addr_i)
      ADDR_MIE:      w_csrVal = {20'h0, r_mieMeie, 11'h0};
      ADDR_MTVEC:    w_csrVal = r_mtvec;
      ADDR_MSCRATCH: w_csrVal = r_mscratch;
      ADDR_MEPC:     w_csrVal = r_mepc;
      ADDR_MCAUSE:   w_csrVal = r_mcause;
      ADDR_CYCLE:    w_csrVal = r_cycle[31:0];
      ADDR_CYCLEH:   w_csrVal = r_cycle[63:32];
      default:       w_known  = 1'b0;
    endcase
  end

  assign w_isCounter   = (csr_addr_i == ADDR_CYCLE) || (csr_addr_i == ADDR_CYCLEH);
  assign w_illegal     = csr_en_i && (!w_known || (w_isCounter && (csr_op_i != OP_READ)));
  assign csr_illegal_o = w_illegal;
  assign csr_rdata_o   = (csr_en_i && !w_illegal) ? w_csrVal : 32'h0;

  // Compute the value a write/clear/set operation would leave behind
  always_comb begin
    w_wnew = w_csrVal;
    case (csr_op_i)
      OP_WRITE: w_wnew = csr_wdata_i;
      OP_CLEAR: w_wnew = w_csrVal & ~csr_wdata_i;
      OP_SET:   w_wnew = w_csrVal | csr_wdata_i;
      default:  w_wnew = w_csrVal;
    endcase
  end

  // A trap in the same cycle swallows any CSR write
  assign w_wrEn          = csr_en_i && !w_illegal && (csr_op_i != OP_READ) && !trap_i;
  assign w_trapPcAligned = trap_pc_i & ALIGN_MASK;

  // CSR storage; trap capture overrides software writes to mepc/mcause
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_mieMeie  <= 1'b0;
      r_mtvec    <= MTVEC_RST & ALIGN_MASK;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
    end else if (trap_i) begin
      r_mepc     <= w_trapPcAligned;
      r_mcause   <= trap_cause_i;
    end else if (w_wrEn) begin
      case (csr_addr_i)
        ADDR_MIE:      r_mieMeie  <= w_wnew[11];
        ADDR_MTVEC:    r_mtvec    <= w_wnew & ALIGN_MASK;
        ADDR_MSCRATCH: r_mscratch <= w_wnew;
        ADDR_MEPC:     r_mepc     <= w_wnew & ALIGN_MASK;
        ADDR_MCAUSE:   r_mcause   <= w_wnew;
        default:       ;
      endcase
    end
  end

  // Free-running 64-bit cycle counter, wraps naturally
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_cycle <= 64'h0;
    else           r_cycle <= r_cycle + 64'd1;
  end

  generate
    if (IRQ_SYNC != 0) begin : g_sync
      logic [1:0] r_irqSync;
      // Two-flop synchronizer for the asynchronous interrupt line
      always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) r_irqSync <= 2'b00;
        else           r_irqSync <= {r_irqSync[0], irq_i};
      end
      assign w_irqLevel = r_irqSync[1];
    end else begin : g_nosync
      assign w_irqLevel = irq_i;
    end
  endgenerate

  assign w_irqRise = w_irqLevel & ~r_irqPrev;

  // Latch interrupt rising edges; an interrupt trap acknowledges, a new edge wins
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_irqPrev    <= 1'b0;
      r_irqPending <= 1'b0;
    end else begin
      r_irqPrev <= w_irqLevel;
      if (w_irqRise)                        r_irqPending <= 1'b1;
      else if (trap_i && trap_cause_i[31])  r_irqPending <= 1'b0;
    end
  end

  // Trap state register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= ST_RUN;
    else           r_state <= w_stateNext;
  end

  // Next state: trap always wins over mret
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_RUN:  if (trap_i) w_stateNext = ST_TRAP;
      ST_TRAP: if (trap_i) w_stateNext = ST_TRAP;
               else if (mret_i) w_stateNext = ST_RUN;
      default: w_stateNext = ST_RUN;
    endcase
  end

  // State-derived outputs: interrupts are only requested while running
  always_comb begin
    w_inRun = (r_state == ST_RUN);
  end

  assign irq_req_o = r_irqPending & r_mieMeie & w_inRun;
  assign mtvec_o   = r_mtvec;
  assign mepc_o    = r_mepc;

endmodule

// File: tb/tb_riscv_csr_unit.sv
// Scoreboard bench for riscv_csr_unit: CSR reads are checked by a monitor
// popping expected results; register outputs are checked directly.
`timescale 1ns/1ps
module tb_riscv_csr_unit;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        csr_en_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_cause_i;
  logic        mret_i;
  logic        irq_i;
  logic        irq_req_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        illegal;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  riscv_csr_unit #(.MTVEC_RST(32'h0000_0103), .IRQ_SYNC(1)) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .csr_en_i     (csr_en_i),
    .csr_op_i     (csr_op_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_rdata_o  (csr_rdata_o),
    .csr_illegal_o(csr_illegal_o),
    .trap_i       (trap_i),
    .trap_pc_i    (trap_pc_i),
    .trap_cause_i (trap_cause_i),
    .mret_i       (mret_i),
    .irq_i        (irq_i),
    .irq_req_o    (irq_req_o),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // Monitor: whenever a CSR access is presented, compare against the oldest expectation
  always @(negedge clk_i) begin
    if (arst_n_i && csr_en_i) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: unexpected CSR access addr=%h rdata=%h", "scoreboard_empty", csr_addr_i, csr_rdata_o);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (csr_rdata_o !== e.rdata || csr_illegal_o !== e.illegal) begin
          errors++;
          $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                   e.name, csr_rdata_o, csr_illegal_o, e.rdata, e.illegal);
        end
      end
    end
  end

  // Issue one CSR access and queue the expected combinational response
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expIllegal);
    exp_t e;
    @(posedge clk_i);
    #1;
    csr_en_i    = 1'b1;
    csr_op_i    = op;
    csr_addr_i  = addr;
    csr_wdata_i = wdata;
    e.name = name; e.rdata = expRdata; e.illegal = expIllegal;
    expQ.push_back(e);
    @(negedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    csr_en_i = 1'b0;
    csr_op_i = 2'b00;
  endtask

  // Direct comparison of a register-level output
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arst_n_i = 1'b0; csr_en_i = 1'b0; csr_op_i = 2'b00; csr_addr_i = 12'h0;
    csr_wdata_i = 32'h0; trap_i = 1'b0; trap_pc_i = 32'h0; trap_cause_i = 32'h0;
    mret_i = 1'b0; irq_i = 1'b0;

    repeat (2) @(negedge clk_i);
    checkOutput("rst_mtvec", mtvec_o, 32'h0000_0100);
    checkOutput("rst_mepc", mepc_o, 32'h0);
    checkOutput("rst_irq_req", {31'b0, irq_req_o}, 32'h0);
    arst_n_i = 1'b1;

    // Counter equals number of rising edges since reset release
    repeat (9) @(posedge clk_i);
    applyStimulus("cycle_10", 2'b00, 12'hC00, 32'h0, 32'd10, 1'b0);

    // Counter wrap from all ones
    @(negedge clk_i);
    force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    #4;
    release dut.r_cycle;
    applyStimulus("cycle_wrap_lo", 2'b00, 12'hC00, 32'h0, 32'h0, 1'b0);
    applyStimulus("cycle_wrap_hi", 2'b00, 12'hC80, 32'h0, 32'h0, 1'b0);

    // mtvec alignment and clear
    applyStimulus("mtvec_wr", 2'b01, 12'h305, 32'h0000_1003, 32'h0000_0100, 1'b0);
    applyStimulus("mtvec_rd", 2'b00, 12'h305, 32'h0, 32'h0000_1000, 1'b0);
    checkOutput("mtvec_o", mtvec_o, 32'h0000_1000);
    applyStimulus("mtvec_clr", 2'b10, 12'h305, 32'h0000_1000, 32'h0000_1000, 1'b0);
    applyStimulus("mtvec_rd0", 2'b00, 12'h305, 32'h0, 32'h0, 1'b0);

    // mscratch write/clear/set
    applyStimulus("mscr_wr", 2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0);
    applyStimulus("mscr_clr", 2'b10, 12'h340, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("mscr_set", 2'b11, 12'h340, 32'h0000_0011, 32'hDEAD_0000, 1'b0);
    applyStimulus("mscr_rd", 2'b00, 12'h340, 32'h0, 32'hDEAD_0011, 1'b0);

    // mepc alignment through software write
    applyStimulus("mepc_wr", 2'b01, 12'h341, 32'h0000_1237, 32'h0, 1'b0);
    applyStimulus("mepc_rd", 2'b00, 12'h341, 32'h0, 32'h0000_1234, 1'b0);
    checkOutput("mepc_o_sw", mepc_o, 32'h0000_1234);

    // Illegal accesses return zero and change nothing
    applyStimulus("ill_wr_c80", 2'b01, 12'hC80, 32'h0000_0005, 32'h0, 1'b1);
    applyStimulus("cycleh_kept", 2'b00, 12'hC80, 32'h0, 32'h0, 1'b0);
    applyStimulus("ill_wr_7c0", 2'b01, 12'h7C0, 32'h1234_5678, 32'h0, 1'b1);
    applyStimulus("ill_rd_7c0", 2'b00, 12'h7C0, 32'h0, 32'h0, 1'b1);
    applyStimulus("mscr_kept", 2'b00, 12'h340, 32'h0, 32'hDEAD_0011, 1'b0);

    // mie keeps only MEIE
    applyStimulus("mie_wr", 2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
    applyStimulus("mie_rd", 2'b00, 12'h304, 32'h0, 32'h0000_0800, 1'b0);

    // Interrupt through synchronizer: not yet after 2 edges, present after 3
    @(posedge clk_i); #1; irq_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("irq_lat2", {31'b0, irq_req_o}, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("irq_lat3", {31'b0, irq_req_o}, 32'h1);

    // Interrupt trap: capture aligned pc and cause, acknowledge pending
    @(posedge clk_i); #1;
    trap_i = 1'b1; trap_pc_i = 32'h0000_0106; trap_cause_i = 32'h8000_000B;
    @(posedge clk_i); #1;
    trap_i = 1'b0;
    @(negedge clk_i);
    checkOutput("trap_mepc", mepc_o, 32'h0000_0104);
    checkOutput("trap_irq_req", {31'b0, irq_req_o}, 32'h0);
    applyStimulus("trap_mcause", 2'b00, 12'h342, 32'h0, 32'h8000_000B, 1'b0);

    // New interrupt edge while in TRAP stays masked until mret
    irq_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1; irq_i = 1'b1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("irq_gated_trap", {31'b0, irq_req_o}, 32'h0);
    @(posedge clk_i); #1; mret_i = 1'b1;
    @(posedge clk_i); #1; mret_i = 1'b0;
    @(negedge clk_i);
    checkOutput("irq_after_mret", {31'b0, irq_req_o}, 32'h1);

    // trap + mret + mepc write together: trap wins, write dropped
    begin
      exp_t e;
      @(posedge clk_i); #1;
      trap_i = 1'b1; trap_pc_i = 32'h0000_0200; trap_cause_i = 32'h0000_0002; mret_i = 1'b1;
      csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h341; csr_wdata_i = 32'h5555_5554;
      e.name = "combo_mepc_rd"; e.rdata = 32'h0000_0104; e.illegal = 1'b0;
      expQ.push_back(e);
      @(posedge clk_i); #1;
      trap_i = 1'b0; mret_i = 1'b0; csr_en_i = 1'b0; csr_op_i = 2'b00;
    end
    @(negedge clk_i);
    checkOutput("combo_mepc", mepc_o, 32'h0000_0200);
    checkOutput("combo_in_trap", {31'b0, irq_req_o}, 32'h0);
    applyStimulus("combo_mcause", 2'b00, 12'h342, 32'h0, 32'h0000_0002, 1'b0);

    // Asynchronous reset while in TRAP with an interrupt pending
    @(posedge clk_i); #3;
    arst_n_i = 1'b0;
    #1;
    checkOutput("arst_irq_req", {31'b0, irq_req_o}, 32'h0);
    checkOutput("arst_mepc", mepc_o, 32'h0);
    checkOutput("arst_mtvec", mtvec_o, 32'h0000_0100);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    applyStimulus("arst_mie", 2'b00, 12'h304, 32'h0, 32'h0, 1'b0);
    applyStimulus("arst_mscr", 2'b00, 12'h340, 32'h0, 32'h0, 1'b0);
    applyStimulus("arst_mcause", 2'b00, 12'h342, 32'h0, 32'h0, 1'b0);
    applyStimulus("arst_cycleh", 2'b00, 12'hC80, 32'h0, 32'h0, 1'b0);
    // irq_i is still high, so a fresh edge is seen after reset; enabling mie proves state is RUN
    applyStimulus("run_mie_wr", 2'b01, 12'h304, 32'h0000_0800, 32'h0, 1'b0);
    @(negedge clk_i);
    checkOutput("run_after_rst", {31'b0, irq_req_o}, 32'h1);

    repeat (2) @(posedge clk_i);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_csr_unit.md
RISCV_CSR_UNIT -- requirements
Module: riscv_csr_unit

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0000, the mtvec reset value (bits [1:0] ignored).
REQ-002 SHALL have parameter IRQ_SYNC, default 1: 1 = 2-flop synchronizer on irq_i, 0 = direct.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port arst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port csr_en_i, input, 1, a CSR instruction is executing this cycle.
REQ-006 SHALL have port csr_op_i, input, 2, op: 00 read-only, 01 write, 10 clear (old & ~wdata), 11 set (old | wdata).
REQ-007 SHALL have port csr_addr_i, input, 12, CSR address.
REQ-008 SHALL have port csr_wdata_i, input, 32, operand.
REQ-009 SHALL have port csr_rdata_o, output, 32, current (pre-update) value of the addressed CSR.
REQ-010 SHALL have port csr_illegal_o, output, 1, unsupported address or write to read-only CSR.
REQ-011 SHALL have port trap_i, input, 1, the core takes a trap this cycle.
REQ-012 SHALL have port trap_pc_i, input, 32, PC to save.
REQ-013 SHALL have port trap_cause_i, input, 32, cause; bit 31 set = interrupt.
REQ-014 SHALL have port mret_i, input, 1, the core executes mret this cycle.
REQ-015 SHALL have port irq_i, input, 1, external interrupt level.
REQ-016 SHALL have port irq_req_o, output, 1, interrupt request to core.
REQ-017 SHALL have ports mtvec_o and mepc_o, output, 32 each, current register values.

Function
REQ-018 SHALL implement mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, cycle-low C00, cycle-high C80; any other address with csr_en_i=1 SHALL assert csr_illegal_o, make csr_rdata_o 0 and change no state.
REQ-019 csr_rdata_o and csr_illegal_o SHALL be combinational from csr_en_i/csr_addr_i/csr_op_i; register update SHALL be visible the next cycle.
REQ-020 Op 01 SHALL write csr_wdata_i, op 10 SHALL clear bits, op 11 SHALL set bits; op 00 SHALL write nothing.
REQ-021 Ops 01/10/11 to C00/C80 SHALL assert csr_illegal_o and not modify the counter; op 00 SHALL be legal.
REQ-022 mtvec and mepc bits [1:0] SHALL always read 0, whatever is written.
REQ-023 mie SHALL store bit 11 (MEIE) only; other bits SHALL read 0.
REQ-024 A 64-bit cycle counter SHALL increment by 1 every cycle; it SHALL wrap from 2^64-1 to 0; C00 SHALL return bits [31:0] and C80 bits [63:32].
REQ-025 On trap_i=1: mepc <= {trap_pc_i[31:2],2'b00}, mcause <= trap_cause_i; any same-cycle CSR write SHALL be dropped (trap has priority).
REQ-026 A two-state FSM SHALL track RUN and TRAP: RUN->TRAP on trap_i; TRAP->RUN on mret_i; trap_i in TRAP SHALL stay TRAP (nested exception updates mepc/mcause).
REQ-027 If trap_i and mret_i are both high, trap_i SHALL win: state TRAP, mepc/mcause updated.
REQ-028 The (optionally synchronized) irq_i rising edge SHALL set irq_pending; a trap with trap_cause_i[31]=1 SHALL clear it; set and clear in the same cycle SHALL leave it set.
REQ-029 irq_req_o SHALL equal irq_pending & mie[11] & (state==RUN), registered-free (combinational from state).
REQ-030 With IRQ_SYNC=1, an irq_i edge SHALL reach irq_pending no earlier than 3 clk_i edges after it is stable.

Reset
REQ-031 On arst_n_i=0 (asynchronous): mtvec=MTVEC_RST & ~3, mie=0, mscratch=0, mepc=0, mcause=0, counter=0, irq_pending=0, synchronizer=0, state=RUN; irq_req_o=0 immediately.
REQ-032 Reset mid-trap SHALL return to RUN with all above values; the first counter increment SHALL follow the first clock edge after deassertion.

Verification
REQ-033 Write 305 op 01 wdata 0x0000_1003, then read 305 -> 0x0000_1000; op 10 wdata 0x1000 -> reads 0.
REQ-034 Read C00 10 cycles after reset -> 10 (±1 per bench sampling rule); force counter 0xFFFF_FFFF_FFFF_FFFF -> next cycle C00=0, C80=0.
REQ-035 Op 01 to C80 or address 0x7C0 -> csr_illegal_o=1, rdata 0, no state change.
REQ-036 mie=0x800, raise irq_i -> irq_req_o=1 after sync; trap_i with cause 0x8000_000B, pc 0x0000_0106 -> mepc=0x104, mcause=0x8000_000B, irq_req_o=0 until mret_i.
REQ-037 trap_i, mret_i and a write to 341 in one cycle -> state TRAP, mepc=trap_pc_i, write ignored.
REQ-038 Assert arst_n_i low in TRAP with irq_pending=1 -> all CSRs reset, irq_req_o=0 within the same cycle.
